// File: rtl/ahb_scspi_master.sv
// ahb_scspi_master: AHB-Lite slave driving a mode-0, MSB-first, 8-bit SPI master
module ahb_scspi_master #(
  parameter int CLK_DIV  = 2,
  parameter bit RESET_SS = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        SPI_CLK,
  output logic        SPI_SS,
  output logic        SPI_SDO,
  input  logic        SPI_MISO,
  output logic        IRQ
);
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  state_t      r_state, w_next;
  logic        r_dp_valid, r_dp_write;
  logic [1:0]  r_dp_idx;
  logic [1:0]  r_ctrl;
  logic        r_done, r_ovr, r_irq, r_ss_hold;
  logic [7:0]  r_div, r_shift, r_rx;
  logic [2:0]  r_bit;
  logic        r_cap;
  logic        w_wr, w_rd, w_tx_wr, w_st_wr, w_ctrl_wr;
  logic        w_tick, w_start, w_fin, w_busy;
  logic        w_unused;
  assign w_unused  = &{1'b0, HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0], HWDATA[31:8]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign IRQ       = r_irq;
  assign SPI_SDO   = r_shift[7];
  assign SPI_SS    = r_ss_hold ? RESET_SS : ~r_ctrl[0];
  assign w_wr      = r_dp_valid & r_dp_write;
  assign w_rd      = r_dp_valid & ~r_dp_write;
  assign w_ctrl_wr = w_wr & (r_dp_idx == 2'd0);
  assign w_st_wr   = w_wr & (r_dp_idx == 2'd1);
  assign w_tx_wr   = w_wr & (r_dp_idx == 2'd2);
  assign w_tick    = r_div == DIV_M1;
  assign w_start   = (r_state == S_IDLE) & w_tx_wr;
  assign w_fin     = (r_state == S_HIGH) & w_tick & (r_bit == 3'd0);
  // Capture the address phase so the data phase knows what it is acting on
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= 2'd0;
    end else begin
      r_dp_valid <= HSEL & HREADY & HTRANS[1];
      r_dp_write <= HWRITE;
      r_dp_idx   <= HADDR[3:2];
    end
  end
  // Control and sticky status bits; a hardware set beats a same-cycle W1C
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ctrl    <= 2'd0;
      r_done    <= 1'b0;
      r_ovr     <= 1'b0;
      r_irq     <= 1'b0;
      r_ss_hold <= 1'b1;
    end else begin
      r_ctrl    <= w_ctrl_wr ? HWDATA[1:0] : r_ctrl;
      r_ss_hold <= r_ss_hold & ~w_ctrl_wr;
      r_done    <= w_fin | (r_done & ~(w_st_wr & HWDATA[1]));
      r_ovr     <= (w_tx_wr & w_busy) | (r_ovr & ~(w_st_wr & HWDATA[2]));
      r_irq     <= r_done & r_ctrl[1];
    end
  end
  // FSM state register
  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // FSM next state: each SCLK half-period lasts CLK_DIV cycles
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_tx_wr ? S_LOW : S_IDLE;
      S_LOW:   w_next = w_tick ? S_HIGH : S_LOW;
      S_HIGH:  w_next = w_tick ? ((r_bit == 3'd0) ? S_IDLE : S_LOW) : S_HIGH;
      default: w_next = S_IDLE;
    endcase
  end
  // FSM outputs
  always_comb begin
    SPI_CLK = r_state == S_HIGH;
    w_busy  = r_state != S_IDLE;
  end
  // Shift datapath: sample MISO at the rising SCLK, shift it in at the falling SCLK
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_div   <= 8'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_cap   <= 1'b0;
      r_rx    <= 8'd0;
    end else begin
      r_div <= (w_start | (w_busy & w_tick)) ? 8'd0 : (w_busy ? r_div + 8'd1 : r_div);
      if (w_start) begin
        r_shift <= HWDATA[7:0];
        r_bit   <= 3'd7;
      end
      if ((r_state == S_LOW) & w_tick) r_cap <= SPI_MISO;
      if ((r_state == S_HIGH) & w_tick & (r_bit != 3'd0)) begin
        r_shift <= {r_shift[6:0], r_cap};
        r_bit   <= r_bit - 3'd1;
      end
      if (w_fin) r_rx <= {r_shift[6:0], r_cap};
    end
  end
  // Read mux, zero outside a read data phase
  always_comb begin
    HRDATA = !w_rd              ? 32'd0 :
             r_dp_idx == 2'd0   ? {30'd0, r_ctrl} :
             r_dp_idx == 2'd1   ? {29'd0, r_ovr, r_done, w_busy} :
             r_dp_idx == 2'd3   ? {24'd0, r_rx} : 32'd0;
  end
endmodule

// File: tb/tb_ahb_scspi_master.sv
// tb_ahb_scspi_master: directed plus randomized checks of the AHB SPI master against a behavioural model
module tb_ahb_scspi_master;
  localparam int D = 2;
  logic        HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = 32'd0, HWDATA = 32'd0;
  logic [1:0]  HTRANS = 2'd0;
  logic [2:0]  HSIZE = 3'd2;
  logic        HREADYOUT, SPI_CLK, SPI_SS, SPI_SDO, SPI_MISO, IRQ;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  int passed = 0, failed = 0, total = 0;
  int n_rise = 0, ss_low = 0, hi_cnt = 0, base = 0, h0, s0;
  logic [7:0]  sdo_seen = 8'd0, pat = 8'd0, tx, exp_rx;
  logic        loop = 1'b1;
  logic [31:0] ra [4];
  logic [31:0] rd_d [4];
  logic [1:0]  m_ctrl;
  logic        m_done, m_ovr;
  logic [7:0]  m_rx;

  ahb_scspi_master #(.CLK_DIV(D), .RESET_SS(1'b1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .SPI_CLK(SPI_CLK),
    .SPI_SS(SPI_SS), .SPI_SDO(SPI_SDO), .SPI_MISO(SPI_MISO), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  // A mode-0 slave: presents bit (7 - rises so far) of its pattern, or echoes MOSI
  assign SPI_MISO = loop ? SPI_SDO : pat[3'(7 - (n_rise - base))];

  always @(posedge SPI_CLK) begin
    n_rise   <= n_rise + 1;
    sdo_seen <= {sdo_seen[6:0], SPI_SDO};
    ss_low   <= ss_low + (SPI_SS ? 0 : 1);
  end

  always @(negedge HCLK) if (SPI_CLK) hi_cnt <= hi_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK);
  endtask

  task automatic rd_seq(input int n);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = ra[0];
    for (int i = 1; i <= n; i++) begin
      @(negedge HCLK);
      rd_d[i-1] = HRDATA;
      chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
      chk("hresp", {30'd0, HRESP}, 32'd0);
      if (i < n) HADDR = ra[i];
      else begin HSEL = 1'b0; HTRANS = 2'b00; end
    end
  endtask

  task automatic rd1(input logic [31:0] a, output logic [31:0] d);
    ra[0] = a;
    rd_seq(1);
    d = rd_d[0];
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    s = 32'd1;
    for (int i = 0; i < 100 && s[0]; i++) rd1(32'h4, s);
    chk("idle_timeout", {31'd0, s[0]}, 32'd0);
  endtask

  function automatic logic [31:0] m_status();
    return {29'd0, m_ovr, m_done, 1'b0};
  endfunction

  task automatic read_all_check(input string tag);
    ra[0] = 32'h0; ra[1] = 32'h4; ra[2] = 32'h8; ra[3] = 32'hC;
    rd_seq(4);
    chk({tag, "_ctrl"}, rd_d[0], {30'd0, m_ctrl});
    chk({tag, "_status"}, rd_d[1], m_status());
    chk({tag, "_txdata"}, rd_d[2], 32'd0);
    chk({tag, "_rxdata"}, rd_d[3], {24'd0, m_rx});
  endtask

  initial begin
    logic [31:0] d;
    m_ctrl = 2'd0; m_done = 1'b0; m_ovr = 1'b0; m_rx = 8'd0;
    repeat (3) @(negedge HCLK);
    chk("rst_sclk", {31'd0, SPI_CLK}, 32'd0);
    chk("rst_ss", {31'd0, SPI_SS}, 32'd1);
    chk("rst_sdo", {31'd0, SPI_SDO}, 32'd0);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    HRESET = 1'b0;
    read_all_check("rst");

    // Loopback 0xA5 with exact DONE timing
    wr(32'h0, 32'h1); m_ctrl = 2'd1;
    loop = 1'b1; base = n_rise; h0 = hi_cnt; s0 = ss_low;
    wr(32'h8, 32'hA5);
    repeat (16*D - 2) @(posedge HCLK);
    ra[0] = 32'h4; ra[1] = 32'h4;
    rd_seq(2);
    chk("a5_busy_before_done", rd_d[0], 32'h1);
    chk("a5_done_on_time", rd_d[1], 32'h2);
    chk("a5_rises", n_rise - base, 8);
    chk("a5_high_cycles", hi_cnt - h0, 8*D);
    chk("a5_ss_low", ss_low - s0, 8);
    chk("a5_sdo", {24'd0, sdo_seen}, 32'hA5);
    m_done = 1'b1; m_rx = 8'hA5;
    rd1(32'hC, d); chk("a5_rx", d, 32'hA5);

    // MISO held high, then W1C of DONE
    loop = 1'b0; pat = 8'hFF; base = n_rise;
    wr(32'h8, 32'h00);
    wait_idle();
    m_rx = 8'hFF;
    rd1(32'hC, d); chk("ff_rx", d, 32'hFF);
    rd1(32'h4, d); chk("ff_status", d, 32'h2);
    wr(32'h4, 32'h2); m_done = 1'b0;
    rd1(32'h4, d); chk("w1c_status", d, 32'h0);

    // Write while busy is ignored and flags overrun
    loop = 1'b1; base = n_rise;
    wr(32'h8, 32'h3C);
    repeat (8) @(posedge HCLK);
    wr(32'h8, 32'h11);
    rd1(32'h4, d); chk("ovr_busy", d, 32'h5);
    wait_idle();
    m_done = 1'b1; m_ovr = 1'b1; m_rx = 8'h3C;
    chk("ovr_rises", n_rise - base, 8);
    chk("ovr_sdo", {24'd0, sdo_seen}, 32'h3C);
    rd1(32'hC, d); chk("ovr_rx", d, 32'h3C);
    rd1(32'h4, d); chk("ovr_status", d, m_status());
    wr(32'h4, 32'h6); m_done = 1'b0; m_ovr = 1'b0;
    rd1(32'h4, d); chk("ovr_cleared", d, 32'h0);

    // IRQ follows DONE & IRQ_EN one cycle late
    wr(32'h0, 32'h2); m_ctrl = 2'd2;
    loop = 1'b1; base = n_rise;
    wr(32'h8, 32'h96);
    repeat (16*D + 1) @(negedge HCLK);
    chk("irq_not_yet", {31'd0, IRQ}, 32'd0);
    @(negedge HCLK);
    chk("irq_rise", {31'd0, IRQ}, 32'd1);
    wr(32'h4, 32'h2);
    @(negedge HCLK);
    chk("irq_lag", {31'd0, IRQ}, 32'd1);
    @(negedge HCLK);
    chk("irq_w1c_low", {31'd0, IRQ}, 32'd0);
    wr(32'h8, 32'h5A);
    wait_idle();
    @(negedge HCLK);
    chk("irq_again", {31'd0, IRQ}, 32'd1);
    wr(32'h0, 32'h0); m_ctrl = 2'd0;
    repeat (2) @(negedge HCLK);
    chk("irq_en_off", {31'd0, IRQ}, 32'd0);
    m_done = 1'b1; m_rx = 8'h5A;
    read_all_check("irq");
    wr(32'h4, 32'h2); m_done = 1'b0;

    // Reset in the middle of a 0xF0 transfer
    wr(32'h0, 32'h1); m_ctrl = 2'd1;
    loop = 1'b0; pat = 8'($urandom); base = n_rise;
    wr(32'h8, 32'hF0);
    for (int i = 0; i < 200 && (n_rise - base) < 4; i++) @(negedge HCLK);
    chk("mid_reached_bit4", {31'd0, (n_rise - base) >= 4}, 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("mid_sclk", {31'd0, SPI_CLK}, 32'd0);
    chk("mid_ss", {31'd0, SPI_SS}, 32'd1);
    chk("mid_sdo", {31'd0, SPI_SDO}, 32'd0);
    HRESET = 1'b0;
    m_ctrl = 2'd0; m_done = 1'b0; m_ovr = 1'b0; m_rx = 8'd0;
    read_all_check("mid");
    wr(32'h0, 32'h1); m_ctrl = 2'd1;
    loop = 1'b1; base = n_rise;
    wr(32'h8, 32'h55);
    wait_idle();
    m_done = 1'b1; m_rx = 8'h55;
    chk("post_rst_sdo", {24'd0, sdo_seen}, 32'h55);
    read_all_check("post_rst");
    wr(32'h4, 32'h2); m_done = 1'b0;

    // Randomized bytes, MISO either looped back or an independent pattern
    for (int k = 0; k < 5; k++) begin
      tx = 8'($urandom);
      pat = 8'($urandom);
      loop = 1'($urandom_range(0, 1));
      base = n_rise;
      wr(32'h8, {24'd0, tx});
      wait_idle();
      exp_rx = loop ? tx : pat;
      m_done = 1'b1; m_rx = exp_rx;
      chk("rnd_rises", n_rise - base, 8);
      chk("rnd_sdo", {24'd0, sdo_seen}, {24'd0, tx});
      read_all_check("rnd");
      wr(32'h4, 32'h2); m_done = 1'b0;
    end
    rd1(32'h4, d); chk("final_status", d, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ahb_scspi_master.md
Name: ahb_scspi_master

Overview:
- AHB-Lite slave SPI master on the MMIO bus, downstream of the processor MMIO master port.
- Drives the system-controller SPI pins (SPI_CLK, SPI_SS, SPI_SDO, SPI_MISO).
- Firmware-driven byte transfers: SPI mode 0, 8-bit frames, MSB first. Software controls slave select; a transfer-done interrupt is optional.

Parameters:
- CLK_DIV, 2, HCLK cycles per SCLK half-period; legal range 1..255.
- RESET_SS, 1, SPI_SS level during and after reset (1 = deasserted).

Ports:
- HCLK  in  1  single clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from MMIO decoder.
- HADDR  in  32  byte address; only [3:2] decoded.
- HTRANS  in  2  transfer type; [1]=1 marks a valid transfer.
- HWRITE  in  1  1=write.
- HSIZE  in  3  ignored; all accesses treated as 32-bit.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready; qualifies the address phase.
- HREADYOUT  out  1  constant 1 (zero wait).
- HRDATA  out  32  read data.
- HRESP  out  2  constant 2'b00 (OKAY).
- SPI_CLK  out  1  SCLK, idle low.
- SPI_SS  out  1  active-low slave select.
- SPI_SDO  out  1  MOSI.
- SPI_MISO  in  1  MISO.
- IRQ  out  1  level interrupt = DONE & IRQ_EN.

Behaviour:
- Address phase: accepted when HSEL & HREADY & HTRANS[1]. Register the word index HADDR[3:2] and HWRITE.
- Write data phase: the cycle after acceptance; HWDATA is applied at the end of that cycle.
- Read data: HRDATA is combinational from the registered index during the data phase; it is 0 when no read is in its data phase.
- Register map:
  - 0x0 CTRL (RW): [0] SS_EN (1 drives SPI_SS=0); [1] IRQ_EN.
  - 0x4 STATUS: [0] BUSY (RO); [1] DONE (sticky, write-1-to-clear); [2] OVR (sticky, write-1-to-clear).
  - 0x8 TXDATA (WO, reads 0): a write of [7:0] starts a transfer when BUSY=0. If BUSY=1 the write is ignored and OVR is set.
  - 0xC RXDATA (RO): [7:0] last completed received byte; [31:8] read as 0.
- Reset values: CTRL=0, DONE=OVR=BUSY=0, RXDATA=0, SPI_CLK=0, SPI_SDO=0, SPI_SS=RESET_SS, IRQ=0, state IDLE.
- FSM states IDLE, LOW, HIGH. Counters: half-period div_cnt (8-bit), bit_cnt (3-bit). 8-bit shift register.
- IDLE:
  - On a TXDATA write data phase: load shift=HWDATA[7:0], bit_cnt=7, div_cnt=0, BUSY=1.
  - Next state LOW.
- LOW:
  - SPI_CLK=0; SPI_SDO=shift[7].
  - When div_cnt==CLK_DIV-1: div_cnt=0, sample SPI_MISO into a capture flop, go to HIGH.
- HIGH:
  - SPI_CLK=1.
  - When div_cnt==CLK_DIV-1 and bit_cnt!=0: shift={shift[6:0],capture}, bit_cnt--, go to LOW.
  - When div_cnt==CLK_DIV-1 and bit_cnt==0: RXDATA={shift[6:0],capture}, DONE=1, BUSY=0, go to IDLE.
- Timing:
  - BUSY rises the cycle after the TXDATA data phase.
  - DONE and RXDATA update exactly 16*CLK_DIV cycles later.
  - A new transfer may start in the cycle DONE is set.
- SPI_SDO holds its last bit in IDLE. SPI_SS=~SS_EN, independent of the FSM.
- Simultaneous events:
  - Hardware DONE set and W1C clear in the same cycle: set wins.
  - Same for OVR.
  - A CTRL write during a transfer takes effect immediately; SS is not gated by BUSY.
- HRESET mid-transfer: FSM returns to IDLE next edge; all outputs take their reset values; the partial byte is discarded and RXDATA is not updated.
- IRQ is registered: it equals DONE & IRQ_EN from the previous cycle.

Test Plan:
- CLK_DIV=2, SPI_MISO looped to SPI_SDO, CTRL=1, write TXDATA=0xA5:
  - 8 SCLK rising edges, high periods 2 cycles each.
  - SDO bits 1,0,1,0,0,1,0,1.
  - DONE set 32 cycles after BUSY rises; RXDATA reads 0x000000A5; SPI_SS=0 throughout.
- SPI_MISO held 1, write TXDATA=0x00:
  - RXDATA=0xFF; STATUS reads 0x2.
  - Write STATUS=0x2; STATUS then reads 0x0.
- Write TXDATA=0x3C, then write TXDATA=0x11 ten cycles later:
  - Second write ignored; OVR=1.
  - SDO stream and RXDATA correspond to 0x3C only.
- CTRL=0x2 (IRQ_EN), complete a transfer:
  - IRQ goes high one cycle after DONE.
  - Write STATUS=0x2 -> IRQ low one cycle after DONE clears.
  - CTRL=0 with DONE set -> IRQ low.
- Assert HRESET at bit 4 of a 0xF0 transfer:
  - Next cycle: SPI_CLK=0, SPI_SS=1, BUSY=0, RXDATA=0.
  - A following 0x55 transfer completes normally.
- Read all four offsets back-to-back with zero wait:
  - HREADYOUT=1 and HRESP=0 every cycle.
  - TXDATA reads 0; unused bits read 0.
